// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter: shares the MMU's single downstream memory port between
// the instruction-read, data-read and data-write requesters. Each requester
// has a one-deep capture slot. Arbitration uses fixed priority W > R > I and
// runs one downstream transaction at a time.
// Optional feature macro: SASANQUA_MEM_ARB_AGING_EN. When defined, an aging
// counter forces an instruction grant after AGING_LIMIT data-side grants.
module mmu_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int AGING_LIMIT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    INST_RDEN,
  input  logic [ADDR_WIDTH-1:0]   INST_RIADDR,
  output logic                    INST_RVALID,
  output logic [ADDR_WIDTH-1:0]   INST_ROADDR,
  output logic [DATA_WIDTH-1:0]   INST_RDATA,
  input  logic                    DATA_RDEN,
  input  logic [ADDR_WIDTH-1:0]   DATA_RIADDR,
  output logic                    DATA_RVALID,
  output logic [ADDR_WIDTH-1:0]   DATA_ROADDR,
  output logic [DATA_WIDTH-1:0]   DATA_RDATA,
  input  logic                    DATA_WREN,
  input  logic [ADDR_WIDTH-1:0]   DATA_WADDR,
  input  logic [DATA_WIDTH/8-1:0] DATA_WSTRB,
  input  logic [DATA_WIDTH-1:0]   DATA_WDATA,
  output logic                    MEM_WAIT,
  output logic                    M_REQ,
  output logic                    M_WE,
  output logic [ADDR_WIDTH-1:0]   M_ADDR,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  input  logic                    M_ACCEPT,
  input  logic                    M_RVALID,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic                    M_BVALID
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_WAIT_W} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_R, OWN_W} own_t;

  state_t r_state;
  own_t   r_owner;
  logic   r_i_flushed;   // in-flight I read belongs to a flushed PC

  logic                    r_i_vld, r_r_vld, r_w_vld;
  logic [ADDR_WIDTH-1:0]   r_i_addr, r_r_addr, r_w_addr;
  logic [DATA_WIDTH/8-1:0] r_w_strb;
  logic [DATA_WIDTH-1:0]   r_w_data;

  logic w_rd_done, w_wr_done;
  logic w_i_clr, w_r_clr, w_w_clr;
  logic w_i_cand, w_i_inflight, w_age_hit;
  logic w_any;
  own_t w_sel;

  assign w_rd_done    = (r_state == S_WAIT_R) && M_RVALID;
  assign w_wr_done    = (r_state == S_WAIT_W) && M_BVALID;
  // A flushed I read must not clear slot I: it may hold the new-PC request.
  assign w_i_clr      = w_rd_done && (r_owner == OWN_I) && !r_i_flushed;
  assign w_r_clr      = w_rd_done && (r_owner == OWN_R);
  assign w_w_clr      = w_wr_done;
  // Slot I is not a candidate while it is being flushed.
  assign w_i_cand     = r_i_vld && !FLUSH;
  assign w_i_inflight = ((r_state == S_ISSUE) || (r_state == S_WAIT_R)) &&
                        (r_owner == OWN_I) && !r_i_flushed;

  assign MEM_WAIT = r_i_vld | r_r_vld | r_w_vld | (r_state != S_IDLE);

`ifdef SASANQUA_MEM_ARB_AGING_EN
  localparam logic [3:0] AGE_LIM = 4'(AGING_LIMIT);
  logic [3:0] r_age;

  // Count data-side grants taken while an instruction request waits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_age <= 4'd0;
    end else if (!r_i_vld) begin
      r_age <= 4'd0;
    end else if ((r_state == S_IDLE) && w_any) begin
      if (w_sel == OWN_I)     r_age <= 4'd0;
      else if (r_age != 4'hF) r_age <= r_age + 4'd1;
    end
  end

  assign w_age_hit = w_i_cand && (r_age == AGE_LIM);
`else
  assign w_age_hit = 1'b0;
`endif

  // Winner selection: aging override, then W > R > I.
  always_comb begin
    w_any = 1'b0;
    w_sel = OWN_I;
    if (w_age_hit) begin
      w_any = 1'b1;
      w_sel = OWN_I;
    end else if (r_w_vld) begin
      w_any = 1'b1;
      w_sel = OWN_W;
    end else if (r_r_vld) begin
      w_any = 1'b1;
      w_sel = OWN_R;
    end else if (w_i_cand) begin
      w_any = 1'b1;
      w_sel = OWN_I;
    end
  end

  // Slot I: a flush frees it (and takes a same-cycle new-PC request).
  // A request is also taken on the edge where the slot completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_i_vld  <= 1'b0;
      r_i_addr <= '0;
    end else if (FLUSH) begin
      r_i_vld <= INST_RDEN;
      if (INST_RDEN) r_i_addr <= INST_RIADDR;
    end else if ((!r_i_vld || w_i_clr) && INST_RDEN) begin
      r_i_vld  <= 1'b1;
      r_i_addr <= INST_RIADDR;
    end else if (w_i_clr) begin
      r_i_vld <= 1'b0;
    end
  end

  // Slot R: capture when empty or completing this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_r_vld  <= 1'b0;
      r_r_addr <= '0;
    end else if ((!r_r_vld || w_r_clr) && DATA_RDEN) begin
      r_r_vld  <= 1'b1;
      r_r_addr <= DATA_RIADDR;
    end else if (w_r_clr) begin
      r_r_vld <= 1'b0;
    end
  end

  // Slot W: capture when empty or completing this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_w_vld  <= 1'b0;
      r_w_addr <= '0;
      r_w_strb <= '0;
      r_w_data <= '0;
    end else if ((!r_w_vld || w_w_clr) && DATA_WREN) begin
      r_w_vld  <= 1'b1;
      r_w_addr <= DATA_WADDR;
      r_w_strb <= DATA_WSTRB;
      r_w_data <= DATA_WDATA;
    end else if (w_w_clr) begin
      r_w_vld <= 1'b0;
    end
  end

  // Transaction FSM with registered downstream request fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_I;
      r_i_flushed <= 1'b0;
      M_REQ       <= 1'b0;
      M_WE        <= 1'b0;
      M_ADDR      <= '0;
      M_WSTRB     <= '0;
      M_WDATA     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_i_flushed <= 1'b0;
          if (w_any) begin
            r_owner <= w_sel;
            r_state <= S_ISSUE;
            M_REQ   <= 1'b1;
            M_WE    <= (w_sel == OWN_W);
            M_WSTRB <= (w_sel == OWN_W) ? r_w_strb : '0;
            M_WDATA <= (w_sel == OWN_W) ? r_w_data : '0;
            case (w_sel)
              OWN_W:   M_ADDR <= r_w_addr;
              OWN_R:   M_ADDR <= r_r_addr;
              default: M_ADDR <= r_i_addr;
            endcase
          end
        end
        S_ISSUE: begin
          if (M_ACCEPT) begin
            M_REQ   <= 1'b0;
            r_state <= M_WE ? S_WAIT_W : S_WAIT_R;
          end
        end
        S_WAIT_R: if (M_RVALID) r_state <= S_IDLE;
        S_WAIT_W: if (M_BVALID) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
      if (FLUSH && w_i_inflight) r_i_flushed <= 1'b1;
    end
  end

  // Route read data back to its owner; flushed I reads are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      INST_RVALID <= 1'b0;
      INST_ROADDR <= '0;
      INST_RDATA  <= '0;
      DATA_RVALID <= 1'b0;
      DATA_ROADDR <= '0;
      DATA_RDATA  <= '0;
    end else begin
      INST_RVALID <= 1'b0;
      DATA_RVALID <= 1'b0;
      if (w_rd_done && (r_owner == OWN_R)) begin
        DATA_RVALID <= 1'b1;
        DATA_ROADDR <= M_ADDR;
        DATA_RDATA  <= M_RDATA;
      end
      if (w_rd_done && (r_owner == OWN_I) && !r_i_flushed && !FLUSH) begin
        INST_RVALID <= 1'b1;
        INST_ROADDR <= M_ADDR;
        INST_RDATA  <= M_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed bench for mmu_mem_arbiter: a vector table of single transactions
// plus hand sequences for priority, stall, flush, aging and reset.
module tb_mmu_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST, FLUSH;
  logic          INST_RDEN, DATA_RDEN, DATA_WREN;
  logic [AW-1:0] INST_RIADDR, DATA_RIADDR, DATA_WADDR;
  logic [3:0]    DATA_WSTRB;
  logic [DW-1:0] DATA_WDATA;
  logic          INST_RVALID, DATA_RVALID, MEM_WAIT;
  logic [AW-1:0] INST_ROADDR, DATA_ROADDR;
  logic [DW-1:0] INST_RDATA, DATA_RDATA;
  logic          M_REQ, M_WE, M_ACCEPT, M_RVALID, M_BVALID;
  logic [AW-1:0] M_ADDR;
  logic [3:0]    M_WSTRB;
  logic [DW-1:0] M_WDATA, M_RDATA;

  always #5 CLK = ~CLK;

  mmu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AGING_LIMIT(2)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_RVALID(INST_RVALID),
    .INST_ROADDR(INST_ROADDR), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_RVALID(DATA_RVALID),
    .DATA_ROADDR(DATA_ROADDR), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WSTRB(DATA_WSTRB),
    .DATA_WDATA(DATA_WDATA), .MEM_WAIT(MEM_WAIT),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WSTRB(M_WSTRB),
    .M_WDATA(M_WDATA), .M_ACCEPT(M_ACCEPT), .M_RVALID(M_RVALID),
    .M_RDATA(M_RDATA), .M_BVALID(M_BVALID)
  );

  // Downstream memory model (auto) or hand-driven responses (manual).
  logic          auto_en;
  logic          mdl_acc, mdl_rv, mdl_bv, man_acc, man_rv, man_bv;
  logic [DW-1:0] mdl_rdata, man_rdata;
  assign M_ACCEPT = auto_en ? mdl_acc   : man_acc;
  assign M_RVALID = auto_en ? mdl_rv    : man_rv;
  assign M_BVALID = auto_en ? mdl_bv    : man_bv;
  assign M_RDATA  = auto_en ? mdl_rdata : man_rdata;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
  } log_t;

  logic [DW-1:0] mem [0:255];
  log_t          lg[$];
  int            acc_dly, resp_dly;
  int            wcnt, rcnt;
  bit            pend, pend_we;
  logic [AW-1:0] pend_addr;

  always @(negedge CLK) begin
    mdl_acc = 1'b0;
    mdl_rv  = 1'b0;
    mdl_bv  = 1'b0;
    if (auto_en) begin
      if (RST) begin
        pend = 1'b0;
        wcnt = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          pend = 1'b0;
          if (pend_we) mdl_bv = 1'b1;
          else begin
            mdl_rv    = 1'b1;
            mdl_rdata = mem[pend_addr[9:2]];
          end
        end else rcnt--;
      end else if (M_REQ) begin
        if (wcnt == acc_dly) begin
          mdl_acc   = 1'b1;
          wcnt      = 0;
          pend      = 1'b1;
          pend_we   = M_WE;
          pend_addr = M_ADDR;
          rcnt      = resp_dly;
          lg.push_back('{M_WE, M_ADDR, M_WDATA, M_WSTRB});
          if (M_WE)
            for (int b = 0; b < 4; b++)
              if (M_WSTRB[b]) mem[M_ADDR[9:2]][8*b +: 8] = M_WDATA[8*b +: 8];
        end else wcnt++;
      end
    end
  end

  // Response pulse counters (bench takes deltas).
  int i_rv_cnt = 0, d_rv_cnt = 0;
  always @(negedge CLK) begin
    if (INST_RVALID) i_rv_cnt++;
    if (DATA_RVALID) d_rv_cnt++;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct packed {
    logic [1:0]  kind;   // 0 = I read, 1 = D read, 2 = D write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [3:0]  lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, i0, d0, idx, nr;
    bit done, stable, mw_ok;

    vt[0] = '{2'd0, 32'h100, 32'h0,        4'h0, 32'h0000_0013, 4'd4};
    vt[1] = '{2'd2, 32'h208, 32'hCAFE_F00D, 4'hF, 32'h0,         4'd4};
    vt[2] = '{2'd1, 32'h208, 32'h0,        4'h0, 32'hCAFE_F00D, 4'd4};
    vt[3] = '{2'd2, 32'h204, 32'hAABB_CCDD, 4'h3, 32'h0,         4'd4};
    vt[4] = '{2'd1, 32'h204, 32'h0,        4'h0, 32'h1122_CCDD, 4'd4};
    vt[5] = '{2'd2, 32'h204, 32'h5566_7788, 4'hC, 32'h0,         4'd4};
    vt[6] = '{2'd0, 32'h204, 32'h0,        4'h0, 32'h5566_CCDD, 4'd4};
    vt[7] = '{2'd1, 32'h3FC, 32'h0,        4'h0, 32'h0,         4'd4};

    for (int k = 0; k < 256; k++) mem[k] = '0;
    mem[32'h100 >> 2] = 32'h0000_0013;
    mem[32'h204 >> 2] = 32'h1122_3344;
    mem[32'h140 >> 2] = 32'h0000_0055;
    mem[0]            = 32'h0000_0093;

    auto_en = 1'b1; acc_dly = 0; resp_dly = 0;
    man_acc = 0; man_rv = 0; man_bv = 0; man_rdata = '0;
    RST = 1'b1; FLUSH = 0;
    INST_RDEN = 0; DATA_RDEN = 0; DATA_WREN = 0;
    INST_RIADDR = '0; DATA_RIADDR = '0; DATA_WADDR = '0;
    DATA_WSTRB = '0; DATA_WDATA = '0;
    repeat (3) tick();

    // Reset state
    chk("rst M_REQ", M_REQ, 0);
    chk("rst MEM_WAIT", MEM_WAIT, 0);
    chk("rst INST_RVALID", INST_RVALID, 0);
    chk("rst DATA_RVALID", DATA_RVALID, 0);
    chk("rst M_ADDR", M_ADDR, 0);
    chk("rst M_WE", M_WE, 0);
    RST = 1'b0;
    tick();

    // Table-driven single transactions
    for (int v = 0; v < 8; v++) begin
      i0 = i_rv_cnt; d0 = d_rv_cnt;
      lg.delete();
      case (vt[v].kind)
        2'd0: begin INST_RDEN = 1; INST_RIADDR = vt[v].addr; end
        2'd1: begin DATA_RDEN = 1; DATA_RIADDR = vt[v].addr; end
        default: begin
          DATA_WREN = 1; DATA_WADDR = vt[v].addr;
          DATA_WDATA = vt[v].wdata; DATA_WSTRB = vt[v].strb;
        end
      endcase
      tick();
      INST_RDEN = 0; DATA_RDEN = 0; DATA_WREN = 0;
      lat = 1; done = 0;
      while (!done && lat < 40) begin
        case (vt[v].kind)
          2'd0:    done = INST_RVALID;
          2'd1:    done = DATA_RVALID;
          default: done = !MEM_WAIT;
        endcase
        if (!done) begin tick(); lat++; end
      end
      chk($sformatf("vec%0d done", v), {31'd0, done}, 1);
      chk($sformatf("vec%0d latency", v), lat, {28'd0, vt[v].lat});
      if (vt[v].kind == 2'd0) begin
        chk($sformatf("vec%0d INST_RDATA", v), INST_RDATA, vt[v].exp);
        chk($sformatf("vec%0d INST_ROADDR", v), INST_ROADDR, vt[v].addr);
      end else if (vt[v].kind == 2'd1) begin
        chk($sformatf("vec%0d DATA_RDATA", v), DATA_RDATA, vt[v].exp);
        chk($sformatf("vec%0d DATA_ROADDR", v), DATA_ROADDR, vt[v].addr);
      end else begin
        chk($sformatf("vec%0d log size", v), lg.size(), 1);
        if (lg.size() == 1) begin
          chk($sformatf("vec%0d M_WE", v), {31'd0, lg[0].we}, 1);
          chk($sformatf("vec%0d M_ADDR", v), lg[0].addr, vt[v].addr);
          chk($sformatf("vec%0d M_WDATA", v), lg[0].data, vt[v].wdata);
          chk($sformatf("vec%0d M_WSTRB", v), {28'd0, lg[0].strb}, {28'd0, vt[v].strb});
        end
      end
      tick(); tick();
      chk($sformatf("vec%0d inst pulses", v), i_rv_cnt - i0, (vt[v].kind == 2'd0) ? 1 : 0);
      chk($sformatf("vec%0d data pulses", v), d_rv_cnt - d0, (vt[v].kind == 2'd1) ? 1 : 0);
    end

    // Simultaneous W, R, I: order W, R, I; R sees the new data
    lg.delete();
    DATA_WREN = 1; DATA_WADDR = 32'h200; DATA_WDATA = 32'hDEAD_BEEF; DATA_WSTRB = 4'hF;
    DATA_RDEN = 1; DATA_RIADDR = 32'h200;
    INST_RDEN = 1; INST_RIADDR = 32'h0;
    tick();
    DATA_WREN = 0; DATA_RDEN = 0; INST_RDEN = 0;
    mw_ok = 1; lat = 0;
    while (!INST_RVALID && lat < 60) begin
      if (!MEM_WAIT) mw_ok = 0;
      tick(); lat++;
    end
    chk("sim INST_RVALID", INST_RVALID, 1);
    chk("sim MEM_WAIT held", {31'd0, mw_ok}, 1);
    chk("sim MEM_WAIT falls", MEM_WAIT, 0);
    chk("sim INST_RDATA", INST_RDATA, 32'h93);
    chk("sim DATA_RDATA", DATA_RDATA, 32'hDEAD_BEEF);
    chk("sim log size", lg.size(), 3);
    if (lg.size() == 3) begin
      chk("sim order0", {lg[0].we, lg[0].addr[30:0]}, {1'b1, 31'h200});
      chk("sim order1", {lg[1].we, lg[1].addr[30:0]}, {1'b0, 31'h200});
      chk("sim order2", {lg[2].we, lg[2].addr[30:0]}, {1'b0, 31'h0});
    end
    tick();

    // Stalled accept; second pulse on the occupied R slot is dropped
    lg.delete(); acc_dly = 5;
    DATA_RDEN = 1; DATA_RIADDR = 32'h208;
    tick();
    DATA_RDEN = 0;
    tick();
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      if (!(M_REQ === 1'b1 && M_ADDR === 32'h208)) stable = 0;
      if (c == 1) begin DATA_RDEN = 1; DATA_RIADDR = 32'h300; end
      tick();
      DATA_RDEN = 0;
    end
    chk("stall M_REQ/M_ADDR stable", {31'd0, stable}, 1);
    lat = 0;
    while (!DATA_RVALID && lat < 40) begin tick(); lat++; end
    chk("stall DATA_RVALID", DATA_RVALID, 1);
    chk("stall DATA_ROADDR", DATA_ROADDR, 32'h208);
    chk("stall DATA_RDATA", DATA_RDATA, 32'hCAFE_F00D);
    tick(); tick();
    chk("stall MEM_WAIT", MEM_WAIT, 0);
    chk("stall one issue", lg.size(), 1);
    acc_dly = 0;

    // Flush while the I read sits in WAIT_R, new PC request same cycle
    lg.delete(); resp_dly = 2; i0 = i_rv_cnt;
    INST_RDEN = 1; INST_RIADDR = 32'h100;
    tick();
    INST_RDEN = 0;
    tick(); tick();
    FLUSH = 1; INST_RDEN = 1; INST_RIADDR = 32'h140;
    tick();
    FLUSH = 0; INST_RDEN = 0;
    lat = 0;
    while (!INST_RVALID && lat < 40) begin tick(); lat++; end
    chk("flush INST_RVALID", INST_RVALID, 1);
    chk("flush INST_ROADDR", INST_ROADDR, 32'h140);
    chk("flush INST_RDATA", INST_RDATA, 32'h55);
    tick(); tick();
    chk("flush pulses", i_rv_cnt - i0, 1);
    chk("flush log size", lg.size(), 2);
    if (lg.size() == 2) begin
      chk("flush old read done", lg[0].addr, 32'h100);
      chk("flush new read", lg[1].addr, 32'h140);
    end
    resp_dly = 0;

    // Aging: I pending under back-to-back R traffic
    lg.delete();
    DATA_RDEN = 1; DATA_RIADDR = 32'h208;
    INST_RDEN = 1; INST_RIADDR = 32'h100;
    tick();
    INST_RDEN = 0;
    lat = 0;
    while ((DATA_RDEN || MEM_WAIT) && lat < 100) begin
      nr = 0;
      foreach (lg[q]) if (lg[q].addr == 32'h208) nr++;
      if (nr >= 4) DATA_RDEN = 0;
      tick(); lat++;
    end
    DATA_RDEN = 0;
    chk("aging drained", MEM_WAIT, 0);
    idx = -1;
    foreach (lg[q]) if (idx < 0 && lg[q].addr == 32'h100) idx = q;
`ifdef SASANQUA_MEM_ARB_AGING_EN
    chk("aging I position", idx, 2);
`else
    chk("aging I position", idx, 4);
`endif
    tick();

    // Reset in WAIT_R followed by a late read response
    auto_en = 0; d0 = d_rv_cnt; i0 = i_rv_cnt;
    DATA_RDEN = 1; DATA_RIADDR = 32'h208;
    tick();
    DATA_RDEN = 0;
    tick();
    chk("rstmid M_REQ up", M_REQ, 1);
    man_acc = 1;
    tick();
    man_acc = 0;
    RST = 1;
    tick();
    RST = 0; man_rv = 1; man_rdata = 32'h1234_5678;
    tick();
    man_rv = 0;
    chk("rstmid DATA_RVALID", DATA_RVALID, 0);
    chk("rstmid DATA_RDATA", DATA_RDATA, 0);
    chk("rstmid DATA_ROADDR", DATA_ROADDR, 0);
    chk("rstmid INST_RDATA", INST_RDATA, 0);
    chk("rstmid M_ADDR", M_ADDR, 0);
    chk("rstmid MEM_WAIT", MEM_WAIT, 0);
    tick();
    chk("rstmid M_REQ idle", M_REQ, 0);
    chk("rstmid no pulses", (d_rv_cnt - d0) + (i_rv_cnt - i0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
